// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, data width, default oversampling and
// the baud divisor formula used by both the receive and transmit paths.
package uart_pkg;

   localparam int unsigned UART_DATA_W     = 8;
   localparam int unsigned UART_OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } uart_state_e;

   // Clocks per oversample tick; never below 1 so the tick generator always runs.
   function automatic int unsigned uart_baud_div(input int unsigned clk_freq,
                                                 input int unsigned baud,
                                                 input int unsigned oversample);
      int unsigned div;
      div = clk_freq / (baud * oversample);
      return (div == 0) ? 1 : div;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side UART signal bundle: serial line in, byte and status strobes out.
interface uart_rx_if;
   import uart_pkg::*;

   logic                   rxd;
   logic [UART_DATA_W-1:0] data;
   logic                   data_valid;
   logic                   frame_err;
   logic                   parity_err;
   logic                   busy;

   modport slave (
      input  rxd,
      output data,
      output data_valid,
      output frame_err,
      output parity_err,
      output busy
   );

   modport master (
      output rxd,
      input  data,
      input  data_valid,
      input  frame_err,
      input  parity_err,
      input  busy
   );

endinterface

// File: rtl/uart_rx_baud_gen.sv
// Oversample tick generator: one-cycle tick every Div clocks, phase reset by restart_i.
module uart_rx_baud_gen #(
   parameter int unsigned Div = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic restart_i,
   output logic tick_o
);

   localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(Div - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      tick_o = (cnt_q == CntLast);
      cnt_d  = cnt_q + 1'b1;
      if (restart_i || tick_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 with 16x-style oversampling and mid-bit sampling.
// Define UART_RX_PARITY_EN to receive 8E1 frames with a live parity_err strobe.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 50_000_000,
   parameter int unsigned BAUD       = 9600,
   parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
   input logic     clk,
   input logic     rst,
   uart_rx_if.slave rx
);

   localparam int unsigned Div  = uart_baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int unsigned OsW  = $clog2(OVERSAMPLE);
   localparam int unsigned IdxW = $clog2(UART_DATA_W);

   localparam logic [OsW-1:0]  OsMid   = OsW'(OVERSAMPLE / 2 - 1);
   localparam logic [OsW-1:0]  OsLast  = OsW'(OVERSAMPLE - 1);
   localparam logic [IdxW-1:0] IdxLast = IdxW'(UART_DATA_W - 1);

   uart_state_e            state_q, state_d;
   logic                   sync1_q, sync1_d;
   logic                   sync2_q, sync2_d;
   logic                   prev_q, prev_d;
   logic [OsW-1:0]         os_q, os_d;
   logic [IdxW-1:0]        idx_q, idx_d;
   logic [UART_DATA_W-1:0] shift_q, shift_d;
   logic [UART_DATA_W-1:0] data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   ferr_q, ferr_d;
   logic                   busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
   logic                   par_bad_q, par_bad_d;
   logic                   perr_q, perr_d;
`endif

   logic tick;
   logic restart;
   logic fall;
   logic bit_end;

   uart_rx_baud_gen #(
      .Div (Div)
   ) u_baud_gen (
      .clk       (clk),
      .rst       (rst),
      .restart_i (restart),
      .tick_o    (tick)
   );

   // Only a genuine 1->0 transition starts a frame; a held-low line never does.
   assign fall    = prev_q & ~sync2_q;
   assign bit_end = tick && (os_q == OsLast);

   always_comb begin
      sync1_d  = rx.rxd;
      sync2_d  = sync1_q;
      prev_d   = sync2_q;
      state_d  = state_q;
      os_d     = os_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      data_d   = data_q;
      busy_d   = busy_q;
      valid_d  = 1'b0;
      ferr_d   = 1'b0;
      restart  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d = par_bad_q;
      perr_d    = 1'b0;
`endif

      if (tick && (state_q != StIdle)) begin
         os_d = bit_end ? '0 : os_q + 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (fall) begin
               state_d = StStart;
               os_d    = '0;
               busy_d  = 1'b1;
               restart = 1'b1;
`ifdef UART_RX_PARITY_EN
               par_bad_d = 1'b0;
`endif
            end
         end
         StStart: begin
            if (tick && (os_q == OsMid)) begin
               os_d = '0;
               if (sync2_q) begin
                  state_d = StIdle;
                  busy_d  = 1'b0;
               end else begin
                  state_d = StData;
                  idx_d   = '0;
               end
            end
         end
         StData: begin
            if (bit_end) begin
               shift_d = {sync2_q, shift_q[UART_DATA_W-1:1]};
               idx_d   = idx_q + 1'b1;
               if (idx_q == IdxLast) begin
`ifdef UART_RX_PARITY_EN
                  state_d = StParity;
`else
                  state_d = StStop;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         StParity: begin
            if (bit_end) begin
               // Even parity: received bit must equal XOR of the data bits.
               par_bad_d = sync2_q ^ (^shift_q);
               state_d   = StStop;
            end
         end
`endif
         StStop: begin
            if (bit_end) begin
               state_d = StIdle;
               busy_d  = 1'b0;
               ferr_d  = ~sync2_q;
`ifdef UART_RX_PARITY_EN
               perr_d = par_bad_q;
               if (sync2_q && !par_bad_q) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
               end
`else
               if (sync2_q) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
               end
`endif
            end
         end
         default: begin
            state_d = StIdle;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         os_q    <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q <= 1'b0;
         perr_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         os_q    <= os_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         busy_q  <= busy_d;
`ifdef UART_RX_PARITY_EN
         par_bad_q <= par_bad_d;
         perr_q    <= perr_d;
`endif
      end
   end

   assign rx.data       = data_q;
   assign rx.data_valid = valid_q;
   assign rx.frame_err  = ferr_q;
   assign rx.busy       = busy_q;
`ifdef UART_RX_PARITY_EN
   assign rx.parity_err = perr_q;
`else
   assign rx.parity_err = 1'b0;
`endif

endmodule
